wb_arbiter_2m: RTL and testbench

Two-master Wishbone (classic cycle) arbiter that shares the single master port of the system interconnect between the CPU bus controller (m0) and a second bus master (m1, e.g. a DMA or debug loader).
- Grants the bus round-robin at cycle boundaries.
- Holds the grant for as long as the owner keeps cyc asserted.
- Routes ack and read data back to the owner.
- Runs a per-transfer watchdog that terminates stalled slave accesses with an error to the owner.
- Sits between the masters and the interconnect's mips_wbm port.

---
 rtl/wb_arbiter_2m.sv | 126 ++++++++++++
 tb/tb_wb_arbiter_2m.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin grant at cycle boundaries,
// owner-routed ack/data, and a per-transfer watchdog that aborts stalled slaves.
module wb_arbiter_2m #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        to_event_o
);
  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;

  localparam int               TO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam bit               WD_EN   = (TIMEOUT > 0);

  state_t             state;
  logic               last_owner;
  logic [1:0]         grant_q;
  logic               to_q;
  logic [CNT_W-1:0]   wd_cnt;
  wb_req_t [1:0]      req;
  wb_req_t            sreq;
  logic               own;
  logic               oidx;
  logic               wd_hit;

  assign req[0] = {m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i};
  assign req[1] = {m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i};

  // rst gates everything combinationally so a transfer cut by reset goes quiet at once
  assign own  = !rst && (state == OWN0 || state == OWN1);
  assign oidx = (state == OWN1);
  assign sreq = own ? req[oidx] : '0;

  assign {s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o} = sreq;

  assign wd_hit = WD_EN && own && sreq.stb && !s_ack_i && (wd_cnt == TO_LAST);

  assign m0_ack_o   = own && !oidx && s_ack_i;
  assign m1_ack_o   = own &&  oidx && s_ack_i;
  assign m0_err_o   = !rst && (state == ERR) && grant_q[0];
  assign m1_err_o   = !rst && (state == ERR) && grant_q[1];
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign grant_o    = rst ? 2'b00 : grant_q;
  assign to_event_o = !rst && to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant_q    <= 2'b00;
      to_q       <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      if (!WD_EN || !own || !sreq.stb || s_ack_i) wd_cnt <= '0;
      else                                         wd_cnt <= wd_cnt + CNT_W'(1);
      to_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
            state      <= OWN0;
            grant_q    <= 2'b01;
            last_owner <= 1'b0;
          end else if (m1_cyc_i) begin
            state      <= OWN1;
            grant_q    <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          // abort wins over a simultaneous cyc drop; grant is kept through ERR
          if (wd_hit) begin
            state <= ERR;
            to_q  <= 1'b1;
          end else if (!req[oidx].cyc) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        ERR: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: two instances (watchdog 8 and disabled) share stimulus
// and are compared every cycle against a transaction-level ownership model.
module tb_wb_arbiter_2m;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_dat [2] = '{32'h0, 32'h0};
  logic [31:0] m_adr [2] = '{32'h0, 32'h0};
  logic [3:0]  m_sel [2] = '{4'h0, 4'h0};
  logic        m_we  [2] = '{1'b0, 1'b0};
  logic        m_cyc [2] = '{1'b0, 1'b0};
  logic        m_stb [2] = '{1'b0, 1'b0};
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;

  logic [31:0] o_dat [2][2];
  logic        o_ack [2][2];
  logic        o_err [2][2];
  logic [31:0] s_dat [2];
  logic [31:0] s_adr [2];
  logic [3:0]  s_sel [2];
  logic        s_we  [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic [1:0]  grant [2];
  logic        to_ev [2];

  int n_vec = 0;
  int n_err = 0;

  // model: owner -1 = nobody, ab = master being aborted this cycle (-1 = none)
  int owner [2] = '{-1, -1};
  int last  [2] = '{1, 1};
  int wcnt  [2] = '{0, 0};
  int ab    [2] = '{-1, -1};
  bit done  [2] = '{1'b0, 1'b0};

  logic [70:0] es;
  logic [1:0]  eg, ea, ee;
  logic        et;
  logic [31:0] rd3 [3] = '{32'h11, 32'h22, 32'h33};
  int          errs1, ev0;
  bit          dead;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter_2m #(.TIMEOUT(g == 0 ? 8 : 0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .m0_dat_i(m_dat[0]), .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
      .m0_dat_o(o_dat[g][0]), .m0_ack_o(o_ack[g][0]), .m0_err_o(o_err[g][0]),
      .m1_dat_i(m_dat[1]), .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
      .m1_dat_o(o_dat[g][1]), .m1_ack_o(o_ack[g][1]), .m1_err_o(o_err[g][1]),
      .s_dat_o(s_dat[g]), .s_adr_o(s_adr[g]), .s_sel_o(s_sel[g]), .s_we_o(s_we[g]),
      .s_cyc_o(s_cyc[g]), .s_stb_o(s_stb[g]),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant[g]), .to_event_o(to_ev[g])
    );
  end

  function automatic int to_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int m);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_we[m]  = 1'($urandom_range(1));
    m_adr[m] = $urandom;
    m_dat[m] = $urandom;
    m_sel[m] = 4'($urandom);
  endtask

  // Ownership model: advanced on every rising edge from the inputs of that cycle.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++)
      done[m] = !rst && ((owner[0] == m && s_ack_i && m_stb[m]) || ab[0] == m);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner[k] = -1; last[k] = 1; wcnt[k] = 0; ab[k] = -1;
      end else if (ab[k] >= 0) begin
        ab[k] = -1;
      end else if (owner[k] >= 0) begin
        if (m_stb[owner[k]] && !s_ack_i) wcnt[k]++;
        else                             wcnt[k] = 0;
        if (to_of(k) > 0 && wcnt[k] == to_of(k)) begin
          ab[k] = owner[k]; owner[k] = -1; wcnt[k] = 0;
        end else if (!m_cyc[owner[k]]) begin
          owner[k] = -1; wcnt[k] = 0;
        end
      end else begin
        if (m_cyc[0] && m_cyc[1]) owner[k] = 1 - last[k];
        else if (m_cyc[0])        owner[k] = 0;
        else if (m_cyc[1])        owner[k] = 1;
        if (owner[k] >= 0) begin
          last[k] = owner[k]; wcnt[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      es = '0; eg = '0; ea = '0; ee = '0; et = 1'b0;
      if (!rst) begin
        if (ab[k] >= 0) begin
          eg[ab[k]] = 1'b1; ee[ab[k]] = 1'b1; et = 1'b1;
        end else if (owner[k] >= 0) begin
          es = {m_dat[owner[k]], m_adr[owner[k]], m_sel[owner[k]], m_we[owner[k]],
                m_cyc[owner[k]], m_stb[owner[k]]};
          eg[owner[k]] = 1'b1;
          ea[owner[k]] = s_ack_i;
        end
      end
      chk($sformatf("sbus%0d", k), {s_dat[k], s_adr[k], s_sel[k], s_we[k], s_cyc[k], s_stb[k]}, es);
      chk($sformatf("grant%0d", k), grant[k], eg);
      chk($sformatf("ack%0d", k), {o_ack[k][1], o_ack[k][0]}, ea);
      chk($sformatf("err%0d", k), {o_err[k][1], o_err[k][0]}, ee);
      chk($sformatf("toev%0d", k), to_ev[k], et);
      chk($sformatf("rdat%0d", k), {o_dat[k][1], o_dat[k][0]}, {s_dat_i, s_dat_i});
    end
  end

  initial begin
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();

    // plain write from m0, slave acks two cycles into the strobe
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0] = 32'h0000_1000; m_dat[0] = 32'hDEAD_BEEF; m_sel[0] = 4'hF;
    #1 chk("t1_lat", s_cyc[0], 1'b0);
    tick();
    chk("t1_cyc", {s_cyc[0], s_stb[0]}, 2'b11);
    chk("t1_adr", s_adr[0], 32'h0000_1000);
    chk("t1_dat", s_dat[0], 32'hDEAD_BEEF);
    chk("t1_gnt", grant[0], 2'b01);
    tick(); tick();
    s_ack_i = 1'b1;
    #1 chk("t1_ack", {o_ack[0][1], o_ack[0][0]}, 2'b01);
    tick();
    s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    tick(); tick();

    // simultaneous request right after reset, then alternation
    rst = 1'b1; tick(); rst = 1'b0; tick();
    m_cyc = '{1'b1, 1'b1}; m_stb = '{1'b1, 1'b1};
    tick();
    chk("t2_first", grant[0], 2'b01);
    s_ack_i = 1'b1; tick();
    s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; tick();
    chk("t2_gap", grant[0], 2'b00);
    tick();
    chk("t2_m1", grant[0], 2'b10);
    s_ack_i = 1'b1; tick();
    s_ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; tick();
    m_cyc = '{1'b1, 1'b1}; m_stb = '{1'b1, 1'b1};
    tick();
    chk("t2_alt", grant[0], 2'b01);
    s_ack_i = 1'b1; tick();
    s_ack_i = 1'b0; m_cyc = '{1'b0, 1'b0}; m_stb = '{1'b0, 1'b0}; tick(); tick();

    // m1 burst under held cyc while m0 waits
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_2000;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_dat_i = rd3[i]; s_ack_i = 1'b1;
      #1;
      chk("t3_rdat", o_dat[0][1], rd3[i]);
      chk("t3_ack", {o_ack[0][1], o_ack[0][0]}, 2'b10);
      chk("t3_gnt", grant[0], 2'b10);
      tick();
    end
    s_ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; tick();
    chk("t3_idle", grant[0], 2'b00);
    tick();
    chk("t3_m0", grant[0], 2'b01);
    s_ack_i = 1'b1; tick();
    s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; tick(); tick();

    // watchdog abort after eight unacked strobe cycles
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t4_stb", s_stb[0], 1'b1);
      tick();
    end
    chk("t4_abort", {o_err[0][0], to_ev[0], s_cyc[0], s_stb[0], grant[0]}, 6'b11_0001);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; tick();
    s_ack_i = 1'b1;
    #1 chk("t4_stray", {o_ack[0][0], o_err[0][0], grant[0]}, 4'b0000);
    tick();
    s_ack_i = 1'b0; tick();

    // ack on the last permitted cycle completes normally
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    repeat (7) tick();
    s_ack_i = 1'b1;
    #1 chk("t5_ack", {o_ack[0][0], o_err[0][0], to_ev[0]}, 3'b100);
    tick();
    s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("t5_noerr", {o_err[0][0], to_ev[0]}, 2'b00);
    tick(); tick();

    // reset in the middle of an m1 transfer, late ack ignored
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick(); tick();
    rst = 1'b1; s_ack_i = 1'b1;
    #1 chk("t6_inrst", {s_cyc[0], s_stb[0], o_ack[0][1], o_err[0][1], grant[0]}, 6'b0);
    tick();
    rst = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1 chk("t6_post", {s_cyc[0], s_stb[0], o_ack[0][0], o_ack[0][1], grant[0], to_ev[0]}, 7'b0);
    s_ack_i = 1'b0;
    tick();
    chk("t6_m0", grant[0], 2'b01);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    errs1 = 0; ev0 = 0;
    repeat (1000) begin
      tick();
      if (o_err[1][0] || o_err[1][1] || to_ev[1]) errs1++;
      if (to_ev[0]) ev0++;
    end
    chk("t6_nowd", errs1, 0);
    chk("t6_wd8", (ev0 >= 90), 1'b1);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; tick(); tick();

    // randomized traffic with compliant masters and a sometimes-dead slave
    dead = 1'b0;
    repeat (4000) begin
      for (int m = 0; m < 2; m++) begin
        if (!m_cyc[m]) begin
          if ($urandom_range(3) == 0) start(m);
        end else if (done[m]) begin
          if ($urandom_range(1) == 0) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
          end else start(m);
        end
      end
      if ($urandom_range(60) == 0) dead = !dead;
      s_ack_i = !dead && ($urandom_range(2) == 0);
      s_dat_i = $urandom;
      rst     = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; s_ack_i = 1'b0;
    m_cyc = '{1'b0, 1'b0}; m_stb = '{1'b0, 1'b0};
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
